// File: rtl/rpn_pkg.sv
// rpn_pkg: opcode and FSM state enums plus default sizing shared by the RPN sequencer and its ALU.
package rpn_pkg;
  localparam int DW_DEF = 4;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [2:0] {OP_LIT, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DROP, OP_CLR} op_t;
  typedef enum logic [2:0] {S_IDLE, S_POP_B, S_CAP_B, S_POP_A, S_CAP_A, S_PUSH} state_t;
endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational binary operator for the RPN sequencer; carry/borrow output exists only under RPN_CARRY_EN.
module rpn_alu import rpn_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_t           op,
`ifdef RPN_CARRY_EN
  output logic          carry,
`endif
  output logic [DW-1:0] y
);
`ifdef RPN_CARRY_EN
  logic [DW:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // dif[DW] is the borrow of a-b
  assign carry = op == OP_ADD ? sum[DW] : dif[DW];
`else
  logic [DW-1:0] sum, dif;
  assign sum = a + b;
  assign dif = a - b;
`endif
  assign y = op == OP_ADD ? sum[DW-1:0] :
             op == OP_SUB ? dif[DW-1:0] :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b : a ^ b;
endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: token-driven RPN sequencer mastering an edge-sensitive hardware stack.
// Optional RPN_CARRY_EN adds a carry/borrow output updated by ADD and SUB.
module rpn_sequencer import rpn_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic [2:0]                   tok_op,
  input  logic [DW-1:0]                tok_data,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [DW-1:0]                stk_wdata,
  input  logic [DW-1:0]                stk_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [DW-1:0]                result,
  output logic                         err_ovf,
  output logic                         err_unf,
`ifdef RPN_CARRY_EN
  output logic                         carry,
`endif
  output logic                         busy
);
  localparam int AW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] FULL = AW'(DEPTH);
  state_t state, state_n;
  op_t op_q, op_in;
  logic [DW-1:0] b_q, y;
  logic acc, is_bin, bin_ok, drop_ok, ovf_set, unf_set, clr;
`ifdef RPN_CARRY_EN
  logic c_alu;
`endif
  // the second operand is the live pop data, so the result is ready at the end of CAP_A
  rpn_alu #(.DW(DW)) u_alu (
    .a(stk_rdata),
    .b(b_q),
    .op(op_q),
`ifdef RPN_CARRY_EN
    .carry(c_alu),
`endif
    .y(y)
  );
  always_comb begin
    op_in = op_t'(tok_op);
    acc = tok_valid & tok_ready;
    is_bin = op_in inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    bin_ok = depth >= AW'(2);
    drop_ok = depth != '0;
    ovf_set = acc & (op_in == OP_LIT) & (depth == FULL);
    unf_set = acc & ((is_bin & !bin_ok) | ((op_in == OP_DROP) & !drop_ok));
    clr = acc & (op_in == OP_CLR);
    state_n = state;
    case (state)
      S_IDLE:  state_n = !acc ? S_IDLE :
                         (op_in == OP_LIT && depth != FULL) ? S_PUSH :
                         ((is_bin && bin_ok) || (op_in == OP_DROP && drop_ok)) ? S_POP_B : S_IDLE;
      S_POP_B: state_n = S_CAP_B;
      S_CAP_B: state_n = op_q == OP_DROP ? S_IDLE : S_POP_A;
      S_POP_A: state_n = S_CAP_A;
      S_CAP_A: state_n = S_PUSH;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= OP_LIT;
      b_q <= '0;
      tok_ready <= 1'b1;
      busy <= 1'b0;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      stk_wdata <= '0;
      depth <= '0;
      result <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
`ifdef RPN_CARRY_EN
      carry <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tok_ready <= state_n == S_IDLE;
      busy <= state_n != S_IDLE;
      stk_push <= state_n == S_PUSH;
      stk_pop <= state_n == S_POP_B || state_n == S_POP_A;
      if (acc) op_q <= op_in;
      if (state == S_CAP_B) b_q <= stk_rdata;
      if (acc && op_in == OP_LIT) stk_wdata <= tok_data;
      if (state == S_CAP_A) begin
        stk_wdata <= y;
        result <= y;
`ifdef RPN_CARRY_EN
        if (op_q inside {OP_ADD, OP_SUB}) carry <= c_alu;
`endif
      end
      if (state == S_PUSH) depth <= depth + AW'(1);
      else if (state == S_POP_B || state == S_POP_A) depth <= depth - AW'(1);
      err_ovf <= !clr & (err_ovf | ovf_set);
      err_unf <= !clr & (err_unf | unf_set);
    end
  end
endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: directed plus random token stream against a queue-based RPN model and a behavioural stack.
module tb_rpn_sequencer;
  logic clk = 0, rst_n = 0, tok_valid = 0;
  logic [2:0] tok_op = 0;
  logic [3:0] tok_data = 0, stk_rdata = 0, stk_wdata, result;
  logic tok_ready, stk_push, stk_pop, err_ovf, err_unf, busy;
  logic [3:0] depth;
`ifdef RPN_CARRY_EN
  logic carry;
`endif
  int total = 0, bad = 0;
  logic [3:0] env_q[$];
  logic [3:0] ref_q[$];
  logic exp_ovf = 0, exp_unf = 0, exp_carry = 0;
  logic [3:0] exp_res = 0;
  rpn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .depth(depth), .result(result),
    .err_ovf(err_ovf), .err_unf(err_unf),
`ifdef RPN_CARRY_EN
    .carry(carry),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  // behavioural 8-deep stack sitting downstream of the sequencer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q.delete();
      stk_rdata <= 0;
    end else begin
      if (stk_push && env_q.size() < 8) env_q.push_back(stk_wdata);
      if (stk_pop && env_q.size() > 0) stk_rdata <= env_q.pop_back();
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      3'd1: r = int'(a) + int'(b);
      3'd2: r = int'(a) - int'(b);
      3'd3: r = int'(a & b);
      3'd4: r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    return r[3:0];
  endfunction
  task automatic check_outputs_reset(input string tag);
    chk({tag, "_ready"}, tok_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_push"}, stk_push, 0);
    chk({tag, "_pop"}, stk_pop, 0);
    chk({tag, "_wdata"}, stk_wdata, 0);
    chk({tag, "_depth"}, depth, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ovf"}, err_ovf, 0);
    chk({tag, "_unf"}, err_unf, 0);
`ifdef RPN_CARRY_EN
    chk({tag, "_carry"}, carry, 0);
`endif
  endtask
  task automatic do_tok(input logic [2:0] op, input logic [3:0] d);
    int e_lat, e_push, e_pop, e_pc, e_p0, e_p1, ready_c, npush, npop, push_c, pop_c0, pop_c1;
    logic [3:0] e_pd, pd, a, b;
    logic both;
    e_lat = 1; e_push = 0; e_pop = 0; e_pc = 0; e_p0 = 0; e_p1 = 0; e_pd = 0;
    if (op == 3'd0) begin
      if (ref_q.size() < 8) begin
        e_lat = 2; e_push = 1; e_pc = 1; e_pd = d;
        ref_q.push_back(d);
      end else exp_ovf = 1;
    end else if (op <= 3'd5) begin
      if (ref_q.size() >= 2) begin
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        e_pd = f(op, a, b);
        if (op == 3'd1) exp_carry = (int'(a) + int'(b)) > 15;
        if (op == 3'd2) exp_carry = a < b;
        ref_q.push_back(e_pd);
        exp_res = e_pd;
        e_lat = 6; e_push = 1; e_pop = 2; e_pc = 5; e_p0 = 1; e_p1 = 3;
      end else exp_unf = 1;
    end else if (op == 3'd6) begin
      if (ref_q.size() >= 1) begin
        void'(ref_q.pop_back());
        e_lat = 3; e_pop = 1; e_p0 = 1;
      end else exp_unf = 1;
    end else begin
      exp_ovf = 0;
      exp_unf = 0;
    end
    @(negedge clk);
    chk("ready_before", tok_ready, 1);
    tok_valid = 1; tok_op = op; tok_data = d;
    @(posedge clk);
    #1 tok_valid = 0; tok_data = 4'($urandom_range(0, 15)); tok_op = 3'($urandom_range(0, 7));
    ready_c = 0; npush = 0; npop = 0; push_c = 0; pop_c0 = 0; pop_c1 = 0; pd = 0; both = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (stk_push) begin npush++; push_c = c; pd = stk_wdata; end
      if (stk_pop) begin npop++; if (npop == 1) pop_c0 = c; else pop_c1 = c; end
      if (stk_push && stk_pop) both = 1;
      chk("busy", busy, c < e_lat);
      if (tok_ready) begin ready_c = c; break; end
    end
    chk("latency", ready_c, e_lat);
    chk("push_count", npush, e_push);
    chk("pop_count", npop, e_pop);
    chk("push_and_pop", both, 0);
    if (e_push != 0) begin
      chk("push_data", pd, e_pd);
      chk("push_cycle", push_c, e_pc);
    end
    if (e_pop != 0) begin
      chk("pop_cycle0", pop_c0, e_p0);
      chk("pop_cycle1", pop_c1, e_p1);
    end
    chk("depth", depth, ref_q.size());
    chk("result", result, exp_res);
    chk("err_ovf", err_ovf, exp_ovf);
    chk("err_unf", err_unf, exp_unf);
`ifdef RPN_CARRY_EN
    chk("carry", carry, exp_carry);
`endif
  endtask
  initial begin
    logic [2:0] op;
    int r;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_outputs_reset("reset");
    do_tok(3'd0, 4'd3);
    do_tok(3'd0, 4'd5);
    do_tok(3'd1, 4'd0);
    do_tok(3'd6, 4'd0);
    do_tok(3'd0, 4'd2);
    do_tok(3'd0, 4'd5);
    do_tok(3'd2, 4'd0);
    do_tok(3'd6, 4'd0);
    do_tok(3'd6, 4'd0);
    do_tok(3'd0, 4'd7);
    do_tok(3'd1, 4'd0);
    do_tok(3'd7, 4'd0);
    do_tok(3'd6, 4'd0);
    for (int i = 0; i < 9; i++) do_tok(3'd0, 4'(i + 3));
    do_tok(3'd7, 4'd0);
    @(negedge clk);
    tok_valid = 1; tok_op = 3'd1;
    @(posedge clk);
    #1 tok_valid = 0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    check_outputs_reset("async_reset");
    ref_q.delete();
    exp_ovf = 0; exp_unf = 0; exp_res = 0; exp_carry = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_outputs_reset("after_release");
    do_tok(3'd0, 4'hF);
    do_tok(3'd0, 4'h1);
    do_tok(3'd1, 4'd0);
    do_tok(3'd0, 4'h1);
    do_tok(3'd2, 4'd0);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      op = r < 40 ? 3'd0 : r < 75 ? 3'($urandom_range(1, 5)) : r < 90 ? 3'd6 : 3'd7;
      do_tok(op, 4'($urandom_range(0, 15)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Token-driven RPN sequencer that sits directly upstream of the 4-bit, 8-deep hardware stack and is its only master. It accepts literal and operator tokens over a valid/ready handshake. It converts each token into correctly spaced push/pop pulses on the stack port and evaluates binary operators on the two top entries. It also tracks stack depth locally, so an illegal push or pop never reaches the stack.

## Interface
- DW, 4, data width; matches stack entry width
- DEPTH, 8, stack capacity; matches stack size
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; also drives the stack's clear
- tok_valid  in  1  token present
- tok_ready  out  1  sequencer can accept a token this cycle
- tok_op  in  3  opcode: 000 LIT, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 DROP, 111 CLR
- tok_data  in  DW  literal value; used only for LIT
- stk_push  out  1  push strobe to stack, one-cycle pulse
- stk_pop  out  1  pop strobe to stack, one-cycle pulse
- stk_wdata  out  DW  push data; valid while stk_push=1
- stk_rdata  in  DW  pop data; valid the cycle after stk_pop=1
- depth  out  clog2(DEPTH+1)  current number of stacked entries
- result  out  DW  last value pushed by an operator
- err_ovf  out  1  sticky: LIT rejected because the stack is full
- err_unf  out  1  sticky: operator or DROP rejected because operands are insufficient
- busy  out  1  FSM not in IDLE

## Operation
- All outputs are registered. Reset values: tok_ready=1, busy=0, stk_push=0, stk_pop=0, stk_wdata=0, depth=0, result=0, err_ovf=0, err_unf=0.
- A token is accepted when tok_valid & tok_ready in IDLE. tok_op and tok_data are captured at acceptance.
- FSM states: IDLE, POP_B, CAP_B, POP_A, CAP_A, PUSH.
- LIT handling:
  - depth<DEPTH: go to PUSH, with stk_wdata=tok_data.
  - depth==DEPTH: set err_ovf and stay in IDLE. The stack is not touched.
- ADD/SUB/AND/OR/XOR handling:
  - depth>=2: sequence is POP_B (pop=1), CAP_B (b<=stk_rdata), POP_A (pop=1), CAP_A (a<=stk_rdata), PUSH (push=1, stk_wdata=a op b, result<=a op b).
  - depth<2: set err_unf and stay in IDLE. No pulses are issued.
- DROP handling:
  - depth>=1: POP_B, then CAP_B, then IDLE. The popped value is discarded.
  - depth==0: set err_unf.
- CLR clears err_ovf and err_unf in the acceptance cycle and stays in IDLE. It does not alter depth or stack contents.
- depth update rules:
  - +1 at the end of PUSH for LIT.
  - -1 at the end of each POP state.
  - Net -1 per binary operator.
- Arithmetic:
  - Result is a op b, truncated to DW bits (mod 2^DW).
  - SUB computes a-b, with a being the older entry.
  - Bitwise operators are per-bit.
- Pop strobes are never issued in adjacent cycles, because the stack is edge-sensitive. Push and pop are never high together.
- Error flags are sticky until CLR or reset. An error does not block later legal tokens.
- Reset mid-operation aborts the FSM immediately and applies all reset values. Any in-flight operands are lost. The stack is cleared by the same rst_n.

## Timing
- tok_ready=1 only in IDLE.
- LIT: acceptance cycle 0, push pulse in cycle 1, ready again in cycle 2.
- Binary operator: pop pulses in cycles 1 and 3, operand captures in cycles 2 and 4, push pulse in cycle 5, ready in cycle 6.
- DROP: pop pulse in cycle 1, ready in cycle 3.
- Rejected token and CLR: flag updates in cycle 1, and tok_ready stays high (back-to-back acceptance allowed).
- stk_rdata is sampled exactly one cycle after the stk_pop pulse.

## Configuration
- RPN_CARRY_EN defined:
  - Adds output port carry (1 bit, reset 0).
  - On ADD, carry = carry-out of a+b.
  - On SUB, carry = borrow (a<b).
  - Other operators leave carry unchanged.
- RPN_CARRY_EN undefined: the port is absent and no carry logic is built.

## Structure
- Shared package rpn_pkg holds:
  - the opcode enum (LIT..CLR)
  - the FSM state enum
  - default DW/DEPTH constants
- One sub-module, rpn_alu: combinational; inputs a, b, op; outputs y and, under RPN_CARRY_EN, carry.

## Test plan
- LIT 3, LIT 5, ADD -> push pulses with data 3, 5, then 8 in cycle 5 after the ADD is accepted; depth ends at 1; result=8.
- LIT 2, LIT 5, SUB -> pushed value 0xD; depth ends at 1.
- Single LIT 7, then ADD -> err_unf=1, no stk_pop pulse, depth stays 1; then CLR -> err_unf=0.
- Nine LITs -> eight push pulses, depth=8, err_ovf=1 on the ninth; stk_push never asserts for the ninth.
- Deassert rst_n during CAP_A of an ADD -> all outputs take reset values asynchronously; tok_ready=1 after release.
- With RPN_CARRY_EN: LIT 0xF, LIT 0x1, ADD -> result=0, carry=1; then LIT 1, SUB -> result=0xF, carry=1.
